led_blink_scheduler: RTL and testbench

- Shares one LED output between N_REQ requesters, each asking for a burst of K blinks at one of four rates.
- The rates are the same four used by the board blinker: 100/50/10/1 Hz at a 25 kHz tick.
- Round-robin arbitration, then a state machine sequences the on/off half-periods and a gap before the next grant.
- Sits between status sources (fault, heartbeat, link) and the board LED pin.

---
 rtl/led_pkg.sv | 40 ++++
 rtl/led_rr_arbiter.sv | 31 +++
 rtl/led_blink_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_led_blink_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default timing constants for the LED blink scheduler.
// The four blink rates match the board blinker (100/50/10/1 Hz at a 25 kHz tick).
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    R100 = 2'b00,
    R50  = 2'b01,
    R10  = 2'b10,
    R1   = 2'b11
  } rate_e;

  localparam int unsigned DEF_CNT_100HZ  = 125;
  localparam int unsigned DEF_CNT_50HZ   = 250;
  localparam int unsigned DEF_CNT_10HZ   = 1250;
  localparam int unsigned DEF_CNT_1HZ    = 12500;
  localparam int unsigned DEF_GAP_CYCLES = 2500;
  localparam int unsigned DEF_CNT_W      = 32;

  // Half-period length in cycles for a rate code.
  function automatic int unsigned rate_to_half(input rate_e       rate,
                                               input int unsigned c100,
                                               input int unsigned c50,
                                               input int unsigned c10,
                                               input int unsigned c1);
    case (rate)
      R100:    return c100;
      R50:     return c50;
      R10:     return c10;
      default: return c1;
    endcase
  endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping around. Grant is one-hot, all zero when nothing is requested.
module led_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    o_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = IDX_W'((32'(i_ptr) + off) % N);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        o_idx = cand;
      end
    end
  end

  assign o_grant = found ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one LED between N_REQ requesters: round-robin grant, then a burst of
// on/off half-periods at the latched rate, then a fixed off gap before re-arbitration.
module led_blink_scheduler
  import led_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned CNT_100HZ  = DEF_CNT_100HZ,
  parameter int unsigned CNT_50HZ   = DEF_CNT_50HZ,
  parameter int unsigned CNT_10HZ   = DEF_CNT_10HZ,
  parameter int unsigned CNT_1HZ    = DEF_CNT_1HZ,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [2*N_REQ-1:0]   i_rate,
  input  logic [4*N_REQ-1:0]   i_blinks,
  output logic [N_REQ-1:0]     o_grant,
  output logic [N_REQ-1:0]     o_done,
  output logic                 o_busy,
  output logic                 o_led_drive
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [3:0]         rem_q, rem_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               req_any;
  logic               owner_req;
  logic               half_end;
  logic [1:0]         rate_sel;
  logic [3:0]         blinks_sel;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  led_rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .o_grant (arb_grant),
    .o_idx   (arb_idx)
  );

  assign req_any    = |i_req;
  assign owner_req  = |(i_req & grant_q);
  assign half_end   = (cnt_q == half_q - CNT_W'(1));
  assign rate_sel   = 2'(i_rate >> {arb_idx, 1'b0});
  assign blinks_sel = 4'(i_blinks >> {arb_idx, 2'b00});

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    rem_d   = rem_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    led_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          grant_d = arb_grant;
          own_d   = arb_idx;
          half_d  = CNT_W'(rate_to_half(rate_e'(rate_sel), CNT_100HZ, CNT_50HZ,
                                        CNT_10HZ, CNT_1HZ));
          rem_d   = blinks_sel;
          cnt_d   = '0;
          if (blinks_sel != 4'd0) begin
            state_d = ST_ON;
            led_d   = 1'b1;
          end else begin
            // Empty burst: grant stays visible for the first gap cycle alongside done.
            state_d = ST_GAP;
            done_d  = arb_grant;
            ptr_d   = wrap_inc(arb_idx);
          end
        end
      end

      ST_ON: begin
        if (!owner_req) begin
          state_d = ST_GAP;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = wrap_inc(own_q);
        end else if (half_end) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          led_d = 1'b1;
        end
      end

      ST_OFF: begin
        if (!owner_req) begin
          state_d = ST_GAP;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = wrap_inc(own_q);
        end else if (half_end) begin
          cnt_d = '0;
          rem_d = rem_q - 4'd1;
          if (rem_q > 4'd1) begin
            state_d = ST_ON;
            led_d   = 1'b1;
          end else begin
            state_d = ST_GAP;
            grant_d = '0;
            done_d  = grant_q;
            ptr_d   = wrap_inc(own_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        grant_d = '0;
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      rem_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      rem_q   <= rem_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;
  // Enable only masks the pin; the sequence keeps running underneath.
  assign o_led_drive = led_q & i_enable;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with short half-periods (4/8/16/32) and a 3-cycle gap.
`timescale 1ns/1ps
module tb_led_blink_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [7:0]  rate;
  logic [15:0] blinks;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        led;

  int tests  = 0;
  int failed = 0;

  led_blink_scheduler #(
    .N_REQ      (4),
    .CNT_100HZ  (4),
    .CNT_50HZ   (8),
    .CNT_10HZ   (16),
    .CNT_1HZ    (32),
    .GAP_CYCLES (3),
    .CNT_W      (32)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_enable    (en),
    .i_req       (req),
    .i_rate      (rate),
    .i_blinks    (blinks),
    .o_grant     (grant),
    .o_done      (done),
    .o_busy      (busy),
    .o_led_drive (led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    req    = 4'b0000;
    rate   = 8'h00;
    blinks = 16'h0000;

    // Reset state
    tick(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done",  32'(done),  0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_led",   32'(led),   0);
    rst_n = 1'b1;
    tick(2);
    chk("rst_idle_busy", 32'(busy), 0);

    // Contention: req 1011, one blink each at rate 00 -> order 0,1,3,0
    begin
      logic [3:0] order [4];
      order[0] = 4'b0001;
      order[1] = 4'b0010;
      order[2] = 4'b1000;
      order[3] = 4'b0001;
      req    = 4'b1011;
      rate   = 8'h00;
      blinks = 16'h1111;
      tick();
      for (int k = 0; k < 4; k++) begin
        chk("rr_grant", 32'(grant), 32'(order[k]));
        chk("rr_led_on", 32'(led), 1);
        tick(8);
        chk("rr_done", 32'(done), 32'(order[k]));
        chk("rr_grant_clr", 32'(grant), 0);
        chk("rr_led_gap", 32'(led), 0);
        if (k == 3) req = 4'b0000;
        tick(4);
      end
      chk("rr_end_grant", 32'(grant), 0);
      chk("rr_end_busy", 32'(busy), 0);
    end

    // Asynchronous reset in the middle of an ON half-period
    req    = 4'b0100;
    rate   = 8'h00;
    blinks = 16'h0300;
    tick();
    chk("arst_grant", 32'(grant), 32'(4'b0100));
    tick(2);
    chk("arst_led_pre", 32'(led), 1);
    chk("arst_busy_pre", 32'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_grant0", 32'(grant), 0);
    chk("arst_busy0",  32'(busy),  0);
    chk("arst_led0",   32'(led),   0);
    chk("arst_done0",  32'(done),  0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick(2);
    chk("arst_idle", 32'(busy), 0);

    // Single burst: req 0 (with req 1 also up, pointer must be back at 0), two blinks at 4/4
    req    = 4'b0011;
    rate   = 8'h00;
    blinks = 16'h0012;
    chk("one_pre_grant", 32'(grant), 0);
    tick();
    chk("one_grant", 32'(grant), 32'(4'b0001));
    chk("one_busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      chk("one_led", 32'(led), 32'((i % 8) < 4));
      chk("one_nodone", 32'(done), 0);
      if (i == 0) begin
        rate   = 8'hFF;
        blinks = 16'h0000;
      end
      tick();
    end
    chk("one_done", 32'(done), 32'(4'b0001));
    chk("one_grant_clr", 32'(grant), 0);
    chk("one_led_gap", 32'(led), 0);
    req = 4'b0000;
    tick();
    chk("one_done_pulse", 32'(done), 0);
    tick();
    chk("one_busy_gap", 32'(busy), 1);
    tick();
    chk("one_busy_idle", 32'(busy), 0);

    // Abort: req 2, rate 11 (32/32), five blinks, dropped after 40 cycles
    req    = 4'b0100;
    rate   = 8'b0011_0000;
    blinks = 16'h0500;
    tick();
    chk("ab_grant", 32'(grant), 32'(4'b0100));
    tick(5);
    req = 4'b0101;
    tick();
    chk("ab_nonowner", 32'(grant), 32'(4'b0100));
    tick(14);
    req = 4'b0100;
    tick(11);
    chk("ab_led_on_last", 32'(led), 1);
    tick();
    chk("ab_led_off_first", 32'(led), 0);
    tick(7);
    chk("ab_grant_held", 32'(grant), 32'(4'b0100));
    req = 4'b0000;
    tick();
    chk("ab_grant_clr", 32'(grant), 0);
    chk("ab_led", 32'(led), 0);
    chk("ab_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      chk("ab_nodone", 32'(done), 0);
      tick();
    end
    chk("ab_idle", 32'(busy), 0);

    // Zero-count request from requester 1
    req    = 4'b0010;
    rate   = 8'h00;
    blinks = 16'h0000;
    tick();
    chk("z_grant", 32'(grant), 32'(4'b0010));
    chk("z_done", 32'(done), 32'(4'b0010));
    chk("z_led", 32'(led), 0);
    chk("z_busy", 32'(busy), 1);
    req = 4'b0000;
    tick();
    chk("z_grant_clr", 32'(grant), 0);
    chk("z_done_clr", 32'(done), 0);
    chk("z_led2", 32'(led), 0);
    tick(2);
    chk("z_idle", 32'(busy), 0);

    // Enable gating: req 3, rate 01 (8/8), two blinks, LED pin masked
    req    = 4'b1000;
    rate   = 8'b0100_0000;
    blinks = 16'h2000;
    en     = 1'b0;
    tick();
    chk("en_grant", 32'(grant), 32'(4'b1000));
    for (int i = 0; i < 32; i++) begin
      chk("en_led", 32'(led), 0);
      chk("en_nodone", 32'(done), 0);
      tick();
    end
    chk("en_done", 32'(done), 32'(4'b1000));
    req = 4'b0000;
    en  = 1'b1;
    tick();
    chk("en_done_clr", 32'(done), 0);
    chk("en_led_gap", 32'(led), 0);
    tick(2);
    chk("en_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
